// File: rtl/alpha_col_packer.sv
// Packs a stream of 64-bit words into J-word columns, A columns per frame.
// Define ALPHA_PACK_ERR_EN to enable s_tlast framing checks (err flag, ABORT state).
module alpha_col_packer #(
    parameter int J = 14,
    parameter int A = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [63:0]     s_tdata,
    input  logic            s_tvalid,
    output logic            s_tready,
    input  logic            s_tlast,
    output logic [J*64-1:0] alpha_u_col,
    output logic            alpha_u_col_tvalid,
    output logic            alpha_u_col_tlast,
    output logic            err,
    output logic            o_dbg_state
);

    localparam int WW = $clog2(J) + 1;
    localparam int CW = $clog2(A) + 1;

    // Handshake: a word transfers on a rising edge where s_tvalid && s_tready;
    // the column output has no ready and is a single-cycle pulse.
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ABORT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WW-1:0]    r_w_cnt;
    logic [CW-1:0]    r_c_cnt;
    logic [J*64-1:0]  r_buf;
    logic [J*64-1:0]  r_col;
    logic             r_col_tvalid;
    logic             r_col_tlast;
    logic             r_err;

    logic             w_xfer;
    logic             w_last_word;
    logic             w_last_col;
    logic             w_frame_end;
    logic             w_early;
    logic             w_missing;
    logic [J*64-1:0]  w_column;

    assign w_last_word = (r_w_cnt == WW'(J - 1));
    assign w_last_col  = (r_c_cnt == CW'(A - 1));
    assign w_frame_end = w_last_word & w_last_col;
    assign w_xfer      = s_tvalid & s_tready;

`ifdef ALPHA_PACK_ERR_EN
    assign s_tready  = rst_n & (r_state == ST_FILL);
    assign w_early   = w_xfer & s_tlast & ~w_frame_end;
    assign w_missing = w_xfer & ~s_tlast & w_frame_end;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = s_tlast;
    assign s_tready  = rst_n;
    assign w_early   = 1'b0;
    assign w_missing = 1'b0;
`endif

    // The closing word bypasses the buffer so the column leaves one cycle after it (J >= 2).
    assign w_column = {r_buf[J*64-1:64], s_tdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_w_cnt      <= '0;
            r_c_cnt      <= '0;
            r_buf        <= '0;
            r_col        <= '0;
            r_col_tvalid <= 1'b0;
            r_col_tlast  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_col_tvalid <= 1'b0;
            r_col_tlast  <= 1'b0;
            case (r_state)
                ST_ABORT: r_state <= ST_FILL;
                default: begin
                    if (w_xfer) begin
                        if (w_early) begin
                            r_err   <= 1'b1;
                            r_w_cnt <= '0;
                            r_c_cnt <= '0;
                            r_buf   <= '0;
                            r_state <= ST_ABORT;
                        end else begin
                            if (w_missing) r_err <= 1'b1;
                            for (int k = 0; k < J; k++) begin
                                if (r_w_cnt == WW'(k)) r_buf[(J-k)*64-1 -: 64] <= s_tdata;
                            end
                            if (w_last_word) begin
                                r_col        <= w_column;
                                r_col_tvalid <= 1'b1;
                                r_col_tlast  <= w_last_col;
                                r_w_cnt      <= '0;
                                r_c_cnt      <= w_last_col ? '0 : r_c_cnt + CW'(1);
                            end else begin
                                r_w_cnt <= r_w_cnt + WW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign alpha_u_col        = r_col;
    assign alpha_u_col_tvalid = r_col_tvalid;
    assign alpha_u_col_tlast  = r_col_tlast;
    assign err                = r_err;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_alpha_col_packer.sv
// Scoreboard bench for alpha_col_packer: expected columns queued at word acceptance, checked at pulses.
module tb_alpha_col_packer;

    localparam int J  = 14;
    localparam int A  = 2;
    localparam int CW = J * 64;
`ifdef ALPHA_PACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [CW-1:0] alpha_u_col;
    logic          alpha_u_col_tvalid;
    logic          alpha_u_col_tlast;
    logic          err;
    logic          dbg_state;

    alpha_col_packer #(.J(J), .A(A)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_tdata            (s_tdata),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .s_tlast            (s_tlast),
        .alpha_u_col        (alpha_u_col),
        .alpha_u_col_tvalid (alpha_u_col_tvalid),
        .alpha_u_col_tlast  (alpha_u_col_tlast),
        .err                (err),
        .o_dbg_state        (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;

    logic [CW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            exp_cyc_q[$];
    logic [CW-1:0] pulse_col_q[$];

    int            m_w = 0;
    int            m_c = 0;
    logic [CW-1:0] m_col = '0;
    logic          exp_err = 1'b0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: shift-in packing, framing rules, expected pulse cycle.
    task automatic model_accept(input logic [63:0] d, input logic last);
        bit frame_end;
        frame_end = (m_w == J - 1) && (m_c == A - 1);
        if (ERR_EN && last && !frame_end) begin
            exp_err = 1'b1;
            m_w = 0;
            m_c = 0;
            m_col = '0;
        end else begin
            if (ERR_EN && !last && frame_end) exp_err = 1'b1;
            m_col = {m_col[CW-65:0], d};
            if (m_w == J - 1) begin
                exp_q.push_back(m_col);
                exp_last_q.push_back(m_c == A - 1);
                exp_cyc_q.push_back(cyc + 1);
                m_w = 0;
                m_c = (m_c == A - 1) ? 0 : m_c + 1;
            end else begin
                m_w++;
            end
        end
    endtask

    // driver tasks
    task automatic send_word(input logic [63:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!s_tready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) begin
            check("ready_timeout", 1, 0);
        end else begin
            s_tdata  = d;
            s_tlast  = last;
            s_tvalid = 1'b1;
            @(posedge clk);
            model_accept(d, last);
            #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic frame_tlast();
        return (m_w == J - 1) && (m_c == A - 1);
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_tready", s_tready, 0);
        check("rst_col", alpha_u_col, 0);
        check("rst_tvalid", alpha_u_col_tvalid, 0);
        check("rst_tlast", alpha_u_col_tlast, 0);
        check("rst_err", err, 0);
        rst_n   = 1'b1;
        m_w     = 0;
        m_c     = 0;
        m_col   = '0;
        exp_err = 1'b0;
        #1;
        check("rst_release_tready", s_tready, 1);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        cyc++;
        if (alpha_u_col_tvalid) begin
            pulses++;
            pulse_col_q.push_back(alpha_u_col);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                check("col", alpha_u_col, exp_q.pop_front());
                check("col_tlast", alpha_u_col_tlast, exp_last_q.pop_front());
                check("col_latency", cyc, exp_cyc_q.pop_front());
                check("err_at_pulse", err, exp_err);
            end
        end else if (alpha_u_col_tlast) begin
            check("tlast_without_valid", 1, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] c;
        logic [63:0]   first;

        do_reset(2);

        // Back-to-back frame of doubles 8.0, 9.0, ... with s_tlast on the last word.
        pulses = 0;
        pulse_col_q.delete();
        for (int k = 0; k < J * A; k++) send_word($realtobits(real'(k + 8)), k == J * A - 1);
        idle(3);
        check("frame_pulses", pulses, 2);
        if (pulse_col_q.size() > 0) begin
            c = pulse_col_q[0];
            check("frame_msb", c[CW-1 -: 64], 64'h4020000000000000);
        end
        check("frame_err", err, 0);

        // Valid toggled every other cycle.
        pulses = 0;
        for (int k = 0; k < J * A; k++) begin
            send_word({$urandom, $urandom}, k == J * A - 1);
            idle(1);
        end
        idle(3);
        check("toggle_pulses", pulses, 2);

        // Reset part-way through a column discards it.
        for (int k = 0; k < 6; k++) send_word({$urandom, $urandom}, 1'b0);
        do_reset(1);
        pulses = 0;
        pulse_col_q.delete();
        first = {$urandom, $urandom};
        send_word(first, 1'b0);
        for (int k = 1; k < J; k++) send_word({$urandom, $urandom}, 1'b0);
        idle(3);
        check("midreset_pulses", pulses, 1);
        if (pulse_col_q.size() > 0) begin
            c = pulse_col_q[0];
            check("midreset_msb", c[CW-1 -: 64], first);
        end

        // Random data with random gaps, finishing the current frame plus one more.
        for (int k = 0; k < J * A + J; k++) begin
            send_word({$urandom, $urandom}, frame_tlast());
            idle($urandom_range(0, 2));
        end
        idle(3);

        // Early s_tlast on word 3 of column 0.
        do_reset(1);
        pulses = 0;
        for (int k = 0; k < 4; k++) send_word({$urandom, $urandom}, k == 3);
        @(negedge clk);
        check("abort_tready", s_tready, ERR_EN ? 0 : 1);
        check("abort_err", err, exp_err);
        check("abort_state", dbg_state, ERR_EN ? 1 : 0);
        @(negedge clk);
        check("abort_tready_back", s_tready, 1);
        check("abort_no_pulse", pulses, 0);
        for (int k = 0; k < J * A; k++) send_word({$urandom, $urandom}, frame_tlast());
        idle(3);
        check("after_abort_err", err, exp_err);

        // Frame with s_tlast missing on its final word.
        do_reset(1);
        for (int k = 0; k < J * A; k++) send_word({$urandom, $urandom}, 1'b0);
        idle(3);
        check("missing_tlast_err", err, ERR_EN ? 1 : 0);

        check("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
